// File: rtl/aibcr3aux_osc_freqmon.sv
// Oscillator frequency monitor: accumulates mod-8 increments of bin_cnt over a win_len-cycle window.
// Latency: done/freq_cnt/ovf appear win_len+2 cycles after an accepted start; start is ignored while busy.
// Optional macro AIBCR3AUX_OSC_FREQMON_SAT_EN: accumulator saturates on overflow instead of wrapping.
module aibcr3aux_osc_freqmon #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       bin_cnt,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, PRIME, MEAS, DONE} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state;
  logic [2:0]       bin_s1;
  logic [2:0]       bin_s2;
  logic [2:0]       prev;
  logic [2:0]       delta;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W:0]   sum;
  logic [WIN_W-1:0] wcnt;
  logic             ovf_acc;
  logic             carry;

  // bin_cnt is a free-running counter, so a 3-bit wrap subtract recovers the edge count.
  always_comb begin
    delta = bin_s2 - prev;
    sum   = {1'b0, acc} + {{(CNT_W-2){1'b0}}, delta};
    carry = sum[CNT_W];
`ifdef AIBCR3AUX_OSC_FREQMON_SAT_EN
    acc_nxt = carry ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
    acc_nxt = sum[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_s1 <= 3'd0;
      bin_s2 <= 3'd0;
    end else begin
      bin_s1 <= bin_cnt;
      bin_s2 <= bin_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 3'd0;
      acc      <= '0;
      wcnt     <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      freq_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort && (win_len != '0)) begin
            state   <= PRIME;
            busy    <= 1'b1;
            wcnt    <= win_len;
            acc     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        PRIME: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            prev  <= bin_s2;
            state <= MEAS;
          end
        end
        MEAS: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc     <= acc_nxt;
            ovf_acc <= ovf_acc | carry;
            prev    <= bin_s2;
            wcnt    <= wcnt - WIN_ONE;
            // Result is captured on entry to DONE so it lines up with the done pulse.
            if (wcnt == WIN_ONE) begin
              state    <= DONE;
              done     <= 1'b1;
              freq_cnt <= acc_nxt;
              ovf      <= ovf_acc | carry;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
